imm_decode_stage: RTL

- Registered, parametrised immediate-decode pipeline stage for the lab CPU. It sits between instruction fetch and the register-read/execute stage.
- Extracts and sign-extends the immediate to XLEN for all instruction formats (I, S, B, U, J). It classifies the format and flags unknown opcodes.
- Uses a valid/ready handshake, so fetch back-pressure and branch flushes are handled in one place.
- Also keeps a saturating count of illegal opcodes for debug.

---
 rtl/imm_pkg.sv | 19 +
 rtl/imm_extract.sv | 51 +++++
 rtl/imm_decode_stage.sv | 68 ++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Opcode and immediate-format encodings shared by the decode stage and its extractor.
package imm_pkg;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;
endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: classifies the opcode and sign-extends its immediate to XLEN.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ENABLE_U_TYPE = 1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);
  // Every format fits in 32 bits already sign-extended from instr[31]; widen once at the end.
  logic [31:0] raw;

  always_comb begin
    raw      = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (instr[6:0])
      OP_IMM, LOAD, JALR: begin
        raw      = {{20{instr[31]}}, instr[31:20]};
        imm_type = IMM_I;
      end
      STORE: begin
        raw      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_type = IMM_S;
      end
      BRANCH: begin
        raw      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_type = IMM_B;
      end
      LUI, AUIPC: begin
        if (ENABLE_U_TYPE != 0) begin
          raw      = {instr[31:12], 12'b0};
          imm_type = IMM_U;
        end else begin
          illegal = 1'b1;
        end
      end
      JAL: begin
        raw      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_type = IMM_J;
      end
      OP:      ;
      default: illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(raw));
endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: valid/ready handshake, flush, and a saturating illegal-opcode counter.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ENABLE_U_TYPE = 1,
  parameter int ILLEGAL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_imm_type,
  output logic                     out_illegal,
  output logic [ILLEGAL_CNT_W-1:0] illegal_count
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_illegal;
  logic            accept;

  imm_extract #(
    .XLEN          (XLEN),
    .ENABLE_U_TYPE (ENABLE_U_TYPE)
  ) u_extract (
    .instr    (in_instr),
    .imm      (dec_imm),
    .imm_type (dec_type),
    .illegal  (dec_illegal)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_instr     <= '0;
      out_imm       <= '0;
      out_imm_type  <= IMM_NONE;
      out_illegal   <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      // Incoming beat is consumed by the handshake but discarded.
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_instr    <= in_instr;
      out_imm      <= dec_imm;
      out_imm_type <= dec_type;
      out_illegal  <= dec_illegal;
      if (dec_illegal && illegal_count != '1)
        illegal_count <= illegal_count + ILLEGAL_CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
